neopixel_frame_sequencer: RTL and testbench
===========================================

# neopixel_frame_sequencer

Frame controller for the NeoPixel peripheral. On a start request from the AXI4-Lite register block, it reads a programmed number of 24-bit GRB pixel words from the pixel buffer RAM and hands them one at a time to the WS2812 bit serializer over a valid/ready handshake. After the last pixel it waits for the serializer to drain, then holds the line low for the latch interval. It sits between the register block and pixel RAM on one side and the serializer on the other.

## Interface
- `ADDR_W`, default 8: pixel RAM address width; maximum frame is 2^ADDR_W pixels.
- `PIXEL_W`, default 24: pixel word width (GRB, G in MSBs).
- `LATCH_CYCLES`, default 30000: latch/reset low time in ACLK cycles (300 µs at 100 MHz); must be ≥2.
- `LATCH_W`, default 16: latch counter width; must satisfy LATCH_CYCLES < 2^LATCH_W.
- `ACLK  in  1`: the only clock.
- `ARESET  in  1`: asynchronous, active-high reset.
- `start  in  1`: one-cycle frame request.
- `abort  in  1`: terminate the current frame early.
- `continuous  in  1`: when high, restart automatically after each latch.
- `num_pixels  in  ADDR_W+1`: pixels per frame, 0..2^ADDR_W.
- `mem_rd_en  out  1`: pixel RAM read strobe.
- `mem_addr  out  ADDR_W`: pixel RAM address.
- `mem_rdata  in  PIXEL_W`: RAM data, valid exactly 1 cycle after `mem_rd_en`.
- `pix_data  out  PIXEL_W`: pixel to the serializer.
- `pix_valid  out  1`: `pix_data` is valid.
- `pix_ready  in  1`: serializer accepts the pixel.
- `ser_idle  in  1`: serializer has finished shifting and its output is low.
- `busy  out  1`: high in every state except IDLE.
- `frame_done  out  1`: one-cycle pulse at the end of each latch.
- `frame_count  out  16`: number of completed, non-aborted frames; wraps modulo 2^16.

## Operation
- **States:** IDLE, FETCH, WAIT, SEND, DRAIN, LATCH.
- **IDLE:**
  - `start`=1 and `num_pixels`≠0: latch `num_pixels` into an internal count, clear the pixel index, go to FETCH.
  - `start` with `num_pixels`=0: ignored; no pulse is generated.
  - `start` in any other state: ignored.
- **FETCH:** drive `mem_rd_en`=1 and `mem_addr`=index, then go to WAIT.
- **WAIT:** register `mem_rdata` into `pix_data`, then go to SEND.
- **SEND:**
  - `pix_valid`=1; `pix_data` stays stable until the handshake.
  - On `pix_valid`&&`pix_ready`: increment the index. If index+1 equals the count, go to DRAIN; otherwise go to FETCH.
- **DRAIN:**
  - Wait for `ser_idle`=1.
  - Then load the latch counter with LATCH_CYCLES-1 and go to LATCH.
- **LATCH:**
  - Decrement the counter each cycle; on the cycle the counter is 0, leave the state. LATCH therefore lasts exactly LATCH_CYCLES cycles.
  - On exit, pulse `frame_done` and increment `frame_count` unless the frame was aborted.
  - If `continuous`=1 and the frame was not aborted, go to FETCH with the index cleared and the same latched count. Otherwise go to IDLE.
- **abort:**
  - Sampled in FETCH, WAIT or SEND: `pix_valid` drops in the next cycle, which is the only permitted valid withdrawal. The block sets an aborted flag and goes to DRAIN.
  - In DRAIN or LATCH: only sets the aborted flag; the latch still completes.
  - In IDLE: no effect.
- The aborted flag is cleared on every entry to FETCH from IDLE.
- **Address:** `mem_addr` is the low ADDR_W bits of the index. A count of 2^ADDR_W reads addresses 0..2^ADDR_W-1 with no wrap inside a frame.

## Timing
- **Reset values:** state IDLE; `mem_rd_en`, `pix_valid`, `busy` and `frame_done` are 0; `mem_addr`, `pix_data` and `frame_count` are 0.
- **Start latency:** `start` sampled at edge N gives `mem_rd_en` high in cycle N+1 and `pix_valid` high in cycle N+3.
- **Per-pixel overhead:** 3 cycles (FETCH, WAIT, handshake cycle) plus any serializer backpressure.
- **DRAIN to latch:** `ser_idle` high at edge M puts LATCH in cycles M+1..M+LATCH_CYCLES, with `frame_done` in cycle M+LATCH_CYCLES+1.
- All outputs are registered.
- `ARESET` asserted mid-frame returns the block to IDLE immediately, with `pix_valid` low asynchronously.
- Simultaneous `start` and `abort` in IDLE: `start` wins; `abort` is ignored.

## Structure
- **`neopixel_pkg`:** state enum `seq_state_t`, `PIXEL_W`, and the default-latch constant. Shared with the register block and the serializer.
- **Sub-module `neopixel_latch_timer`:** loadable down-counter with a `zero` flag. Reused by the serializer for its bit timing.

## Test plan
- `num_pixels`=3, RAM = 0x0000FF/0x00FF00/0xFF0000, `pix_ready` always 1 → three handshakes in address order with exact data; `pix_valid` first high 3 cycles after `start`; `frame_done` once; `frame_count`=1.
- `pix_ready` held low for 10 cycles on pixel 1 → `pix_data` and `pix_valid` stable for all 10 cycles; no extra RAM reads.
- `ser_idle` low for 50 cycles after the last handshake, LATCH_CYCLES=8 → `frame_done` exactly 59 cycles after the last handshake.
- `continuous`=1, `num_pixels`=2 → two full frames back-to-back. Clear `continuous` during frame 2 → return to IDLE after it; `frame_count`=2.
- `abort` in SEND on pixel 1 of 4 → `pix_valid` low next cycle; DRAIN and LATCH complete; `frame_done` pulses; `frame_count` unchanged.
- `num_pixels`=256 (ADDR_W=8) → addresses 0..255 read once each. `start` with `num_pixels`=0 → `busy` stays 0. `ARESET` mid-frame → all outputs at reset values.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared NeoPixel peripheral types and constants used by the register block,
// the frame sequencer and the bit serializer.
package neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_LATCH = 3'd5
    } seq_state_t;

    localparam int PIXEL_W              = 24;
    localparam int LATCH_CYCLES_DEFAULT = 30000;

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// Pixel RAM read port plus the pixel stream towards the WS2812 serializer.
interface neopixel_frame_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int PIXEL_W = neopixel_pkg::PIXEL_W
);
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIXEL_W-1:0] mem_rdata;
    logic [PIXEL_W-1:0] pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic               ser_idle;

    modport master (
        output mem_rd_en, mem_addr, pix_data, pix_valid,
        input  mem_rdata, pix_ready, ser_idle
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_data, pix_valid,
        output mem_rdata, pix_ready, ser_idle
    );
endinterface

// File: rtl/neopixel_latch_timer.sv
// Loadable down-counter that parks at zero; also used for serializer bit timing.
module neopixel_latch_timer #(
    parameter int W = 16
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);
    logic [W-1:0] count_r;

    // Load takes priority over the decrement.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != '0) begin
            count_r <= count_r - W'(1);
        end
    end

    assign zero = (count_r == '0);
endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Frame controller: fetches pixels from RAM, streams them to the serializer,
// then waits for drain and holds the latch interval.
module neopixel_frame_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int PIXEL_W      = neopixel_pkg::PIXEL_W,
    parameter int LATCH_CYCLES = neopixel_pkg::LATCH_CYCLES_DEFAULT,
    parameter int LATCH_W      = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      continuous,
    input  logic [ADDR_W:0]           num_pixels,
    neopixel_frame_sequencer_if.master bus,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);
    import neopixel_pkg::*;

    localparam logic [ADDR_W:0]  IDX_ONE    = (ADDR_W + 1)'(1);
    localparam logic [LATCH_W-1:0] LATCH_LOAD = LATCH_W'(LATCH_CYCLES - 1);

    seq_state_t         state_r, state_next_s;
    logic [ADDR_W:0]    index_r, index_next_s, index_inc_s;
    logic [ADDR_W:0]    count_r, count_next_s;
    logic               aborted_r, aborted_next_s;
    logic               timer_load_s, timer_zero_s, frame_end_s;
    logic               mem_rd_en_r, pix_valid_r, busy_r, frame_done_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [PIXEL_W-1:0] pix_data_r;
    logic [15:0]        frame_count_r;

    assign index_inc_s = index_r + IDX_ONE;

    neopixel_latch_timer #(.W(LATCH_W)) u_latch_timer (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .load       (timer_load_s),
        .load_value (LATCH_LOAD),
        .zero       (timer_zero_s)
    );

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort in the late states only marks the frame.
    always_comb begin
        state_next_s   = state_r;
        index_next_s   = index_r;
        count_next_s   = count_r;
        aborted_next_s = aborted_r;
        timer_load_s   = 1'b0;
        frame_end_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (num_pixels != '0)) begin
                    state_next_s   = ST_FETCH;
                    count_next_s   = num_pixels;
                    index_next_s   = '0;
                    aborted_next_s = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH, ST_WAIT: begin
                if (abort) begin
                    state_next_s   = ST_DRAIN;
                    aborted_next_s = 1'b1;
                end else if (state_r == ST_FETCH) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_next_s   = ST_DRAIN;
                    aborted_next_s = 1'b1;
                end else if (pix_valid_r && bus.pix_ready) begin
                    index_next_s = index_inc_s;
                    if (index_inc_s == count_r) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DRAIN: begin
                aborted_next_s = aborted_r | abort;
                if (bus.ser_idle) begin
                    timer_load_s = 1'b1;
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_LATCH: begin
                aborted_next_s = aborted_r | abort;
                if (timer_zero_s) begin
                    frame_end_s = 1'b1;
                    if (continuous && !aborted_next_s) begin
                        state_next_s = ST_FETCH;
                        index_next_s = '0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_LATCH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers, all decoded from the next state.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            index_r       <= '0;
            count_r       <= '0;
            aborted_r     <= 1'b0;
            mem_rd_en_r   <= 1'b0;
            mem_addr_r    <= '0;
            pix_data_r    <= '0;
            pix_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            index_r      <= index_next_s;
            count_r      <= count_next_s;
            aborted_r    <= aborted_next_s;
            mem_rd_en_r  <= (state_next_s == ST_FETCH);
            pix_valid_r  <= (state_next_s == ST_SEND);
            busy_r       <= (state_next_s != ST_IDLE);
            frame_done_r <= frame_end_s;
            if (state_next_s == ST_FETCH) begin
                mem_addr_r <= index_next_s[ADDR_W-1:0];
            end
            if (state_r == ST_WAIT) begin
                pix_data_r <= bus.mem_rdata;
            end
            if (frame_end_s && !aborted_next_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign bus.mem_rd_en = mem_rd_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.pix_data  = pix_data_r;
    assign bus.pix_valid = pix_valid_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign frame_count   = frame_count_r;
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Self-checking bench: RAM model, expected read/pixel queues and a per-cycle
// monitor, driven by directed frame scenarios.
module tb_neopixel_frame_sequencer;
    localparam int ADDR_W       = 8;
    localparam int PIXEL_W      = 24;
    localparam int LATCH_CYCLES = 8;
    localparam int LATCH_W      = 16;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              continuous = 1'b0;
    logic [ADDR_W:0]   num_pixels = '0;
    logic              busy, frame_done;
    logic [15:0]       frame_count;
    logic              ready_q = 1'b1;
    logic              idle_q = 1'b1;

    neopixel_frame_sequencer_if #(.ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W)) bus ();

    neopixel_frame_sequencer #(
        .ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W),
        .LATCH_CYCLES(LATCH_CYCLES), .LATCH_W(LATCH_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .continuous(continuous), .num_pixels(num_pixels), .bus(bus),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 ACLK = ~ACLK;

    assign bus.pix_ready = ready_q;
    assign bus.ser_idle  = idle_q;

    logic [PIXEL_W-1:0] ram [0:255];
    always @(posedge ACLK) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: what the frame rules say must appear on the bus.
    logic [ADDR_W-1:0]  exp_addr [$];
    logic [PIXEL_W-1:0] exp_pix [$];
    logic [PIXEL_W-1:0] hs_log [$];
    int   exp_fc = 0;
    logic model_aborted = 1'b0;
    int   hs_count = 0, rd_count = 0, fd_count = 0;
    int   last_hs_edge = 0, last_fd_edge = 0;
    int   first_rd_edge = -1, first_valid_edge = -1;
    logic prev_stall = 1'b0;
    logic [PIXEL_W-1:0] prev_data = '0;

    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_fc = 0;
            prev_stall = 1'b0;
            exp_addr.delete();
            exp_pix.delete();
        end else begin
            if (bus.mem_rd_en) begin
                rd_count++;
                if (first_rd_edge < 0) first_rd_edge = cyc;
                check("read_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.pix_valid && first_valid_edge < 0) first_valid_edge = cyc;
            if (bus.pix_valid && bus.pix_ready) begin
                hs_count++;
                last_hs_edge = cyc + 1;
                hs_log.push_back(bus.pix_data);
                check("pix_expected", 32'(exp_pix.size() > 0), 32'd1);
                if (exp_pix.size() > 0) check("pix_data", 32'(bus.pix_data), 32'(exp_pix.pop_front()));
            end
            if (prev_stall) begin
                check("valid_hold", 32'(bus.pix_valid), 32'd1);
                check("data_hold", 32'(bus.pix_data), 32'(prev_data));
            end
            prev_stall = bus.pix_valid && !bus.pix_ready && !abort;
            prev_data  = bus.pix_data;
            if (frame_done) begin
                fd_count++;
                last_fd_edge = cyc;
                if (!model_aborted) exp_fc = (exp_fc + 1) % 65536;
            end
            check("frame_count", 32'(frame_count), 32'(exp_fc));
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_start(input int n);
        model_aborted = 1'b0;
        first_rd_edge = -1;
        first_valid_edge = -1;
        num_pixels = (ADDR_W + 1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_frame(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'(i));
            exp_pix.push_back(ram[i]);
        end
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int k = 0;
        while (fd_count < target && k < budget) begin tick(); k++; end
        check(name, 32'(fd_count), 32'(target));
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int k = 0;
        while (hs_count < target && k < budget) begin tick(); k++; end
        check(name, 32'(hs_count), 32'(target));
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!bus.pix_valid && k < 20) begin tick(); k++; end
        check(name, 32'(bus.pix_valid), 32'd1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
        check({name, "_pix_left"}, 32'(exp_pix.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_frame_done"}, 32'(frame_done), 32'd0);
        check({name, "_frame_count"}, 32'(frame_count), 32'd0);
        check({name, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check({name, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({name, "_pix_data"}, 32'(bus.pix_data), 32'd0);
        check({name, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
    endtask

    initial begin
        int start_edge, h0, r0, k, hs_base;
        for (int i = 0; i < 256; i++) begin
            ram[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
        end
        ram[0] = 24'h0000FF;
        ram[1] = 24'h00FF00;
        ram[2] = 24'hFF0000;

        // Reset values.
        repeat (3) tick();
        check_all_zero("reset");
        ARESET = 1'b0;
        tick();

        // Three pixels, serializer always ready.
        expect_frame(3);
        hs_base = hs_log.size();
        do_start(3);
        start_edge = cyc;
        wait_fd(1, 200, "t1_done");
        check("t1_rd_latency", 32'(first_rd_edge - start_edge), 32'd0);
        check("t1_valid_latency", 32'(first_valid_edge - start_edge), 32'd2);
        check("t1_px0", 32'(hs_log[hs_base]), 32'h0000FF);
        check("t1_px1", 32'(hs_log[hs_base + 1]), 32'h00FF00);
        check("t1_px2", 32'(hs_log[hs_base + 2]), 32'hFF0000);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check_drained("t1");
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Backpressure on pixel 1 for 10 cycles.
        expect_frame(3);
        h0 = hs_count;
        r0 = rd_count;
        do_start(3);
        wait_hs(h0 + 1, 50, "t2_first_hs");
        ready_q = 1'b0;
        wait_valid("t2_valid");
        repeat (10) tick();
        ready_q = 1'b1;
        wait_fd(2, 200, "t2_done");
        check("t2_reads", 32'(rd_count - r0), 32'd3);
        check_drained("t2");

        // Serializer busy for 50 cycles after the last handshake.
        idle_q = 1'b0;
        expect_frame(1);
        h0 = hs_count;
        do_start(1);
        wait_hs(h0 + 1, 50, "t3_hs");
        repeat (50) tick();
        idle_q = 1'b1;
        wait_fd(3, 200, "t3_done");
        check("t3_drain_to_done", 32'(last_fd_edge - last_hs_edge), 32'd59);
        check("t3_frame_count", 32'(frame_count), 32'd3);

        // Continuous mode: two back-to-back frames, then stop.
        continuous = 1'b1;
        expect_frame(2);
        expect_frame(2);
        r0 = rd_count;
        do_start(2);
        k = 0;
        while (!frame_done && k < 200) begin tick(); k++; end
        check("t4_first_done", 32'(frame_done), 32'd1);
        check("t4_restart_rd", 32'(bus.mem_rd_en), 32'd1);
        check("t4_restart_busy", 32'(busy), 32'd1);
        continuous = 1'b0;
        wait_fd(5, 200, "t4_done");
        repeat (2) tick();
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_reads", 32'(rd_count - r0), 32'd4);
        check("t4_frame_count", 32'(frame_count), 32'd5);
        check_drained("t4");

        // Abort while pixel 1 of 4 waits in SEND.
        exp_addr.push_back(ADDR_W'(0));
        exp_addr.push_back(ADDR_W'(1));
        exp_pix.push_back(ram[0]);
        h0 = hs_count;
        r0 = rd_count;
        do_start(4);
        wait_hs(h0 + 1, 50, "t5_first_hs");
        ready_q = 1'b0;
        wait_valid("t5_valid");
        abort = 1'b1;
        model_aborted = 1'b1;
        tick();
        abort = 1'b0;
        ready_q = 1'b1;
        check("t5_valid_drop", 32'(bus.pix_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        wait_fd(6, 200, "t5_done");
        tick();
        check("t5_frame_count", 32'(frame_count), 32'd5);
        check("t5_reads", 32'(rd_count - r0), 32'd2);
        check("t5_idle", 32'(busy), 32'd0);
        check_drained("t5");

        // Full 256-pixel frame.
        expect_frame(256);
        r0 = rd_count;
        do_start(256);
        wait_fd(7, 2000, "t6_done");
        check("t6_reads", 32'(rd_count - r0), 32'd256);
        check("t6_frame_count", 32'(frame_count), 32'd6);
        check_drained("t6");

        // Zero-length start is ignored.
        r0 = rd_count;
        do_start(0);
        for (int i = 0; i < 5; i++) begin
            check("t7_busy", 32'(busy), 32'd0);
            tick();
        end
        check("t7_reads", 32'(rd_count - r0), 32'd0);

        // Reset mid-frame while a pixel is presented.
        expect_frame(4);
        h0 = hs_count;
        do_start(4);
        wait_hs(h0 + 1, 50, "t8_first_hs");
        ready_q = 1'b0;
        wait_valid("t8_valid");
        #2;
        ARESET = 1'b1;
        #1;
        check_all_zero("t8_reset");
        tick();
        ARESET = 1'b0;
        ready_q = 1'b1;
        tick();
        check("t8_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
